// File: rtl/color_seq_checker.sv
// Color sequence checker.
// Watches a stream of color symbols and flags three kinds of violation,
// one per symbol, with fixed priority: illegal color code, then a run of
// identical colors longer than MAX_RUN, then a forbidden ordered pair.
// The history (last color, run length) and a saturating violation counter
// are exposed as registered outputs.
module color_seq_checker #(
  parameter int CW         = 2,
  parameter int NUM_COLORS = 3,
  parameter int MAX_RUN    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [CW-1:0] color,
  input  logic          forbid_en,
  input  logic [CW-1:0] forbid_from,
  input  logic [CW-1:0] forbid_to,
  output logic          check,
  output logic [1:0]    err_code,
  output logic [3:0]    run_len,
  output logic [CW-1:0] last_color,
  output logic          hist_vld,
  output logic [15:0]   viol_cnt
);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_RUN     = 2'd1;
  localparam logic [1:0] ERR_PAIR    = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  // One extra bit so NUM_COLORS == 2**CW is representable.
  localparam logic [CW:0] NUM_COLORS_W = (CW+1)'(NUM_COLORS);
  localparam logic [4:0]  MAX_RUN_W    = 5'(MAX_RUN);
  // run_len is 4 bits wide; with MAX_RUN=15 it pins at 15, and the
  // violation test below still works because it uses the 5-bit increment.
  localparam logic [3:0]  RUN_SAT      = (MAX_RUN >= 15) ? 4'd15 : 4'(MAX_RUN + 1);

  logic          check_q,      check_d;
  logic [1:0]    err_code_q,   err_code_d;
  logic [3:0]    run_len_q,    run_len_d;
  logic [CW-1:0] last_color_q, last_color_d;
  logic          hist_vld_q,   hist_vld_d;
  logic [15:0]   viol_cnt_q,   viol_cnt_d;
  logic [4:0]    run_inc_s;
  logic          illegal_s;

  // Next-state: classify the incoming symbol and update history/counter.
  always_comb begin
    run_inc_s    = {1'b0, run_len_q} + 5'd1;
    illegal_s    = ({1'b0, color} >= NUM_COLORS_W);
    check_d      = 1'b0;
    err_code_d   = ERR_NONE;
    run_len_d    = run_len_q;
    last_color_d = last_color_q;
    hist_vld_d   = hist_vld_q;
    if (clear) begin
      run_len_d    = 4'd0;
      last_color_d = '0;
      hist_vld_d   = 1'b0;
    end else if (in_valid) begin
      if (illegal_s) begin
        // Illegal code: flagged, history untouched.
        check_d    = 1'b1;
        err_code_d = ERR_ILLEGAL;
      end else if (!hist_vld_q) begin
        last_color_d = color;
        run_len_d    = 4'd1;
        hist_vld_d   = 1'b1;
      end else if (color == last_color_q) begin
        run_len_d = (run_inc_s > {1'b0, RUN_SAT}) ? RUN_SAT : run_inc_s[3:0];
        if (run_inc_s > MAX_RUN_W) begin
          check_d    = 1'b1;
          err_code_d = ERR_RUN;
        end else begin
          check_d    = 1'b0;
          err_code_d = ERR_NONE;
        end
      end else begin
        // Different color: the pair rule can only fire here, so a
        // forbid_from == forbid_to setting never produces a pair error.
        last_color_d = color;
        run_len_d    = 4'd1;
        if (forbid_en && (last_color_q == forbid_from) && (color == forbid_to)) begin
          check_d    = 1'b1;
          err_code_d = ERR_PAIR;
        end else begin
          check_d    = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
    end else begin
      check_d    = 1'b0;
      err_code_d = ERR_NONE;
    end

    if (clear) begin
      viol_cnt_d = 16'd0;
    end else if (check_d && (viol_cnt_q != 16'hFFFF)) begin
      viol_cnt_d = viol_cnt_q + 16'd1;
    end else begin
      viol_cnt_d = viol_cnt_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      run_len_q    <= 4'd0;
      last_color_q <= '0;
      hist_vld_q   <= 1'b0;
      viol_cnt_q   <= 16'd0;
    end else begin
      check_q      <= check_d;
      err_code_q   <= err_code_d;
      run_len_q    <= run_len_d;
      last_color_q <= last_color_d;
      hist_vld_q   <= hist_vld_d;
      viol_cnt_q   <= viol_cnt_d;
    end
  end

  assign check      = check_q;
  assign err_code   = err_code_q;
  assign run_len    = run_len_q;
  assign last_color = last_color_q;
  assign hist_vld   = hist_vld_q;
  assign viol_cnt   = viol_cnt_q;

endmodule

// File: tb/tb_color_seq_checker.sv
// Self-checking bench for color_seq_checker (default parameters).
module tb_color_seq_checker;

  localparam int CW = 2;
  localparam int NC = 3;
  localparam int MR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [CW-1:0] color;
  logic          forbid_en;
  logic [CW-1:0] forbid_from;
  logic [CW-1:0] forbid_to;
  logic          check;
  logic [1:0]    err_code;
  logic [3:0]    run_len;
  logic [CW-1:0] last_color;
  logic          hist_vld;
  logic [15:0]   viol_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (plain integers, unbounded run count).
  int m_last, m_run, m_viol, m_check, m_err;
  bit m_hist;

  color_seq_checker #(.CW(CW), .NUM_COLORS(NC), .MAX_RUN(MR)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .color(color), .forbid_en(forbid_en), .forbid_from(forbid_from),
    .forbid_to(forbid_to), .check(check), .err_code(err_code),
    .run_len(run_len), .last_color(last_color), .hist_vld(hist_vld),
    .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input bit v, input bit c, input int col);
    in_valid = v;
    clear    = c;
    color    = CW'(col);
    @(posedge clk);
    #1;
  endtask

  // Behavioural rules of the checker, applied to one input cycle.
  task automatic model_step(input bit v, input bit c, input int col);
    m_check = 0;
    m_err   = 0;
    if (c) begin
      m_hist = 0; m_run = 0; m_last = 0; m_viol = 0;
    end else if (v) begin
      if (col >= NC) begin
        m_err = 3;
      end else if (!m_hist) begin
        m_hist = 1; m_last = col; m_run = 1;
      end else if (col == m_last) begin
        m_run = m_run + 1;
        if (m_run > MR) m_err = 1;
      end else begin
        if (forbid_en && m_last == int'(forbid_from) && col == int'(forbid_to)) m_err = 2;
        m_last = col;
        m_run  = 1;
      end
      if (m_err != 0) begin
        m_check = 1;
        if (m_viol < 65535) m_viol = m_viol + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; color = '0;
    forbid_en = 1'b0; forbid_from = '0; forbid_to = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({check, err_code, run_len, last_color, hist_vld, viol_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset: outputs=%h expected all zero",
               {check, err_code, run_len, last_color, hist_vld, viol_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_run();
    int cols[4]  = '{1, 1, 1, 1};
    int exp_c[4] = '{0, 0, 1, 1};
    int exp_e[4] = '{0, 0, 1, 1};
    int exp_r[4] = '{1, 2, 3, 3};
    drive(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, cols[i]);
      n_cmp++;
      if (check !== 1'(exp_c[i]) || err_code !== 2'(exp_e[i]) || run_len !== 4'(exp_r[i])) begin
        n_bad++;
        $display("FAIL run[%0d]: check=%0d err=%0d run_len=%0d expected %0d %0d %0d",
                 i, check, err_code, run_len, exp_c[i], exp_e[i], exp_r[i]);
      end
    end
    n_cmp++;
    if (viol_cnt !== 16'd2) begin
      n_bad++; $display("FAIL run_viol: viol_cnt=%0d expected 2", viol_cnt);
    end
    // Idle cycle: flag drops, history holds.
    drive(0, 0, 2);
    n_cmp++;
    if (check !== 1'b0 || err_code !== 2'd0 || run_len !== 4'd3 || last_color !== 2'd1 || viol_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL idle: check=%0d err=%0d run_len=%0d last=%0d viol=%0d expected 0 0 3 1 2",
               check, err_code, run_len, last_color, viol_cnt);
    end
  endtask

  task automatic test_pair();
    int cols[3]  = '{0, 2, 2};
    int exp_c[3] = '{0, 1, 0};
    int exp_e[3] = '{0, 2, 0};
    drive(0, 1, 0);
    forbid_en = 1'b1; forbid_from = 2'd0; forbid_to = 2'd2;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, cols[i]);
      n_cmp++;
      if (check !== 1'(exp_c[i]) || err_code !== 2'(exp_e[i])) begin
        n_bad++;
        $display("FAIL pair[%0d]: check=%0d err=%0d expected %0d %0d",
                 i, check, err_code, exp_c[i], exp_e[i]);
      end
    end
    n_cmp++;
    if (last_color !== 2'd2 || run_len !== 4'd2) begin
      n_bad++; $display("FAIL pair_hist: last=%0d run_len=%0d expected 2 2", last_color, run_len);
    end
    // Same-color forbidden pair never raises a pair error.
    drive(0, 1, 0);
    forbid_from = 2'd1; forbid_to = 2'd1;
    drive(1, 0, 1);
    drive(1, 0, 1);
    n_cmp++;
    if (check !== 1'b0 || err_code !== 2'd0) begin
      n_bad++; $display("FAIL pair_same: check=%0d err=%0d expected 0 0", check, err_code);
    end
    forbid_en = 1'b0;
  endtask

  task automatic test_illegal();
    int cols[3]  = '{0, 3, 0};
    int exp_c[3] = '{0, 1, 0};
    int exp_e[3] = '{0, 3, 0};
    drive(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, cols[i]);
      n_cmp++;
      if (check !== 1'(exp_c[i]) || err_code !== 2'(exp_e[i])) begin
        n_bad++;
        $display("FAIL illegal[%0d]: check=%0d err=%0d expected %0d %0d",
                 i, check, err_code, exp_c[i], exp_e[i]);
      end
    end
    n_cmp++;
    if (run_len !== 4'd2 || last_color !== 2'd0 || viol_cnt !== 16'd1) begin
      n_bad++; $display("FAIL illegal_hist: run_len=%0d last=%0d viol=%0d expected 2 0 1",
                        run_len, last_color, viol_cnt);
    end
  endtask

  task automatic test_clear();
    drive(0, 1, 0);
    drive(1, 0, 2);
    drive(1, 0, 2);
    n_cmp++;
    if (check !== 1'b0 || run_len !== 4'd2) begin
      n_bad++; $display("FAIL clear_pre: check=%0d run_len=%0d expected 0 2", check, run_len);
    end
    drive(1, 1, 2);
    n_cmp++;
    if (check !== 1'b0 || hist_vld !== 1'b0 || run_len !== 4'd0 || viol_cnt !== 16'd0) begin
      n_bad++; $display("FAIL clear_cyc: check=%0d hist=%0d run_len=%0d viol=%0d expected 0 0 0 0",
                        check, hist_vld, run_len, viol_cnt);
    end
    drive(1, 0, 2);
    n_cmp++;
    if (check !== 1'b0 || run_len !== 4'd1 || viol_cnt !== 16'd0 || hist_vld !== 1'b1) begin
      n_bad++; $display("FAIL clear_post: check=%0d run_len=%0d viol=%0d hist=%0d expected 0 1 0 1",
                        check, run_len, viol_cnt, hist_vld);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({check, err_code, run_len, last_color, hist_vld, viol_cnt} !== '0) begin
      n_bad++; $display("FAIL async_reset: outputs=%h expected all zero",
                        {check, err_code, run_len, last_color, hist_vld, viol_cnt});
    end
    #1 rst_n = 1'b1;
    drive(1, 0, 0);
    n_cmp++;
    if (check !== 1'b0 || run_len !== 4'd1 || hist_vld !== 1'b1 || last_color !== 2'd0) begin
      n_bad++; $display("FAIL after_reset: check=%0d run_len=%0d hist=%0d last=%0d expected 0 1 1 0",
                        check, run_len, hist_vld, last_color);
    end
  endtask

  task automatic test_random();
    bit v, c;
    int col, exp_rl;
    forbid_en = 1'b0; forbid_from = 2'd0; forbid_to = 2'd1;
    drive(0, 1, 0);
    model_step(0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 49) == 0);
      if (c) begin
        forbid_from = CW'($urandom_range(0, 3));
        forbid_to   = CW'($urandom_range(0, 3));
      end
      forbid_en = ($urandom_range(0, 3) != 0);
      v   = ($urandom_range(0, 3) != 0);
      col = (i % 40 < 20) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      model_step(v, c, col);
      drive(v, c, col);
      exp_rl = (m_run > MR + 1) ? MR + 1 : m_run;
      n_cmp++;
      if (check !== 1'(m_check) || err_code !== 2'(m_err) || run_len !== 4'(exp_rl) ||
          hist_vld !== m_hist || viol_cnt !== 16'(m_viol) ||
          (m_hist && last_color !== CW'(m_last))) begin
        n_bad++;
        $display("FAIL random[%0d]: chk=%0d err=%0d rl=%0d hv=%0d vc=%0d lc=%0d expected %0d %0d %0d %0d %0d %0d",
                 i, check, err_code, run_len, hist_vld, viol_cnt, last_color,
                 m_check, m_err, exp_rl, m_hist, m_viol, m_last);
      end
    end
  endtask

  task automatic test_saturation();
    drive(0, 1, 0);
    in_valid = 1'b1; clear = 1'b0; color = 2'd3;
    for (int i = 1; i <= 65540; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (check !== 1'b1 || err_code !== 2'd3) begin
        n_bad++; $display("FAIL sat_flag[%0d]: check=%0d err=%0d expected 1 3", i, check, err_code);
      end
      if (i == 65534) begin
        n_cmp++;
        if (viol_cnt !== 16'hFFFE) begin
          n_bad++; $display("FAIL sat_pre: viol_cnt=%h expected fffe", viol_cnt);
        end
      end
      if (i >= 65535) begin
        n_cmp++;
        if (viol_cnt !== 16'hFFFF) begin
          n_bad++; $display("FAIL sat_hold[%0d]: viol_cnt=%h expected ffff", i, viol_cnt);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (hist_vld !== 1'b0 || run_len !== 4'd0) begin
      n_bad++; $display("FAIL sat_hist: hist=%0d run_len=%0d expected 0 0", hist_vld, run_len);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pair();
    test_illegal();
    test_clear();
    test_async_reset();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/color_seq_checker.md
COLOR_SEQ_CHECKER -- requirements
Module: color_seq_checker

Interface
REQ-001 Parameter CW, default 2, color symbol width in bits (1..8).
REQ-002 Parameter NUM_COLORS, default 3, number of legal colors; codes 0..NUM_COLORS-1 are legal (2..2^CW).
REQ-003 Parameter MAX_RUN, default 2, maximum legal count of consecutive identical accepted colors (1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous clear of history and counters.
REQ-007 in_valid  input  1  color is presented this cycle.
REQ-008 color  input  CW  color symbol.
REQ-009 forbid_en  input  1  enables the forbidden-transition rule.
REQ-010 forbid_from, forbid_to  input  CW each  forbidden ordered pair (previous -> current); quasi-static.
REQ-011 check  output  1  registered violation flag for the previous cycle's symbol.
REQ-012 err_code  output  2  registered violation type: 0 none, 1 run, 2 pair, 3 illegal color.
REQ-013 run_len  output  4  current run length of last_color, saturating at MAX_RUN+1.
REQ-014 last_color  output  CW  last accepted color; meaningful only when hist_vld=1.
REQ-015 hist_vld  output  1  at least one color accepted since reset/clear.
REQ-016 viol_cnt  output  16  count of violations since reset/clear, saturating at 16'hFFFF.

Function
REQ-017 A symbol is sampled when in_valid=1 and clear=0; check/err_code update on the same edge (1-cycle latency from sample to flag).
REQ-018 Cycles with in_valid=0 and clear=0 drive check=0, err_code=0 and leave all history unchanged.
REQ-019 Illegal color (color >= NUM_COLORS): check=1, err_code=3; last_color, run_len, hist_vld unchanged.
REQ-020 Legal color with hist_vld=0: accepted, last_color=color, run_len=1, hist_vld=1, check=0.
REQ-021 Legal color equal to last_color: run_len increments, saturating at MAX_RUN+1; violation code 1 if the new run length exceeds MAX_RUN.
REQ-022 Legal color different from last_color: run_len=1; violation code 2 if forbid_en=1, last_color==forbid_from and color==forbid_to.
REQ-023 Priority when several rules hit: 3 > 1 > 2; only one err_code reported, viol_cnt incremented by exactly one.
REQ-024 Run and pair violations still accept the symbol into history (last_color, run_len updated).
REQ-025 viol_cnt increments by 1 on each cycle check is set to 1, holds at 16'hFFFF.
REQ-026 clear=1: hist_vld=0, run_len=0, last_color=0, viol_cnt=0, check=0, err_code=0; a simultaneous in_valid symbol is dropped.
REQ-027 With MAX_RUN=1 any two consecutive identical legal colors flag code 1.
REQ-028 forbid_from==forbid_to never triggers code 2 (same-color path uses the run rule only).

Reset
REQ-029 rst_n=0 asynchronously forces check=0, err_code=0, run_len=0, last_color=0, hist_vld=0, viol_cnt=0, independent of clk.
REQ-030 Reset asserted mid-stream discards history; first legal color after release behaves per REQ-020.

Verification (defaults CW=2, NUM_COLORS=3, MAX_RUN=2)
REQ-031 Colors 1,1,1,1 back-to-back -> check 0,0,1,1; err_code 0,0,1,1; run_len ends at 3; viol_cnt=2.
REQ-032 forbid_en=1, from=0, to=2; colors 0,2,2 -> check 0,1,0; err_code 0,2,0; last_color=2.
REQ-033 Colors 0,3,0 -> check 0,1,0; err_code 0,3,0; run_len=2 after third symbol (3 ignored).
REQ-034 Colors 2,2 then clear with in_valid=1 color=2, then 2 -> check 0 throughout; run_len=1, viol_cnt=0.
REQ-035 rst_n pulsed low between clock edges after 0,0,0 -> outputs zero immediately; next 0 gives check=0, run_len=1.
REQ-036 Force viol_cnt to 16'hFFFF via 65536 illegal colors -> check pulses each cycle, viol_cnt holds 16'hFFFF.
